// File: rtl/fb_scanout_reader_if.sv
// -----------------------------------------------------------------------------
// fb_scanout_reader_if: raster timing, frame-buffer read port and RGB output bus
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface fb_scanout_reader_if;
  logic        de_in;
  logic        hs_in;
  logic        vs_in;
  logic [1:0]  palette;
  logic [23:0] bgcolour;
  logic [12:0] fb_addr;
  logic [1:0]  fb_data;
  logic [23:0] rgb;
  logic        de_out;
  logic        hs_out;
  logic        vs_out;

  modport master (
    output de_in, hs_in, vs_in, palette, bgcolour, fb_data,
    input  fb_addr, rgb, de_out, hs_out, vs_out
  );

  modport slave (
    input  de_in, hs_in, vs_in, palette, bgcolour, fb_data,
    output fb_addr, rgb, de_out, hs_out, vs_out
  );
endinterface

`default_nettype wire

// File: rtl/fb_scanout_reader.sv
// -----------------------------------------------------------------------------
// fb_scanout_reader: scales raster timing onto a 2bpp frame buffer, palette-maps to RGB
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fb_scanout_reader #(
  parameter int H_SCALE  = 10,
  parameter int V_SCALE  = 11,
  parameter int V_OFFSET = 8,
  parameter int FB_W     = 128,
  parameter int FB_H     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fb_scanout_reader_if.slave   bus
);

  localparam int XW  = $clog2(FB_W);
  localparam int AYW = $clog2(FB_H);
  localparam int YW  = $clog2(FB_H + 1);
  localparam int HW  = $clog2(H_SCALE);
  localparam int VW  = $clog2(V_SCALE);

  localparam logic [HW-1:0] H_LAST   = HW'(H_SCALE - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_SCALE - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(FB_W - 1);
  localparam logic [YW-1:0] Y_END    = YW'(FB_H);
  localparam logic [9:0]    LINE_OFF = 10'(V_OFFSET);
  localparam logic [9:0]    LINE_MAX = 10'd1023;

  logic          vs_q, de_q;
  logic [HW-1:0] h_sub;
  logic [XW-1:0] fb_x;
  logic [9:0]    line_cnt;
  logic [VW-1:0] v_sub;
  logic [YW-1:0] fb_y;
  logic [1:0]    pal_q;
  logic [23:0]   bg_q;
  logic [12:0]   addr_q;
  logic [1:0]    de_pipe, hs_pipe, vs_pipe, img_pipe;
  logic [23:0]   rgb_q;
  logic          de_o, hs_o, vs_o;

  logic          frame_start, de_fall, in_img;
  logic [7:0]    level;
  logic [23:0]   pal_rgb, rgb_next;

  assign frame_start = bus.vs_in & ~vs_q;
  assign de_fall     = de_q & ~bus.de_in;
  assign in_img      = (line_cnt >= LINE_OFF) && (fb_y < Y_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= bus.vs_in;
      de_q <= bus.de_in;
    end
  end

  // Horizontal scaler: fb_x saturates so an overlong line repeats the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sub <= '0;
      fb_x  <= '0;
    end else if (!bus.de_in) begin
      h_sub <= '0;
      fb_x  <= '0;
    end else if (h_sub == H_LAST) begin
      h_sub <= '0;
      if (fb_x != X_LAST) fb_x <= fb_x + 1'b1;
    end else begin
      h_sub <= h_sub + 1'b1;
    end
  end

  // Frame start takes priority over an end-of-line in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt <= '0;
      v_sub    <= '0;
      fb_y     <= '0;
      pal_q    <= '0;
      bg_q     <= '0;
    end else if (frame_start) begin
      line_cnt <= '0;
      v_sub    <= '0;
      fb_y     <= '0;
      pal_q    <= bus.palette;
      bg_q     <= bus.bgcolour;
    end else if (de_fall) begin
      if (line_cnt != LINE_MAX) line_cnt <= line_cnt + 10'd1;
      if (line_cnt >= LINE_OFF) begin
        if (v_sub == V_LAST) begin
          v_sub <= '0;
          if (fb_y != Y_END) fb_y <= fb_y + 1'b1;
        end else begin
          v_sub <= v_sub + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      de_pipe  <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      img_pipe <= '0;
      rgb_q    <= '0;
      de_o     <= 1'b0;
      hs_o     <= 1'b0;
      vs_o     <= 1'b0;
    end else begin
      if (in_img) addr_q <= {fb_y[AYW-1:0], fb_x};
      de_pipe  <= {de_pipe[0],  bus.de_in};
      hs_pipe  <= {hs_pipe[0],  bus.hs_in};
      vs_pipe  <= {vs_pipe[0],  bus.vs_in};
      img_pipe <= {img_pipe[0], in_img};
      rgb_q    <= rgb_next;
      de_o     <= de_pipe[1];
      hs_o     <= hs_pipe[1];
      vs_o     <= vs_pipe[1];
    end
  end

  // Index 0 always shows the frame's background colour.
  always_comb begin
    level    = 8'h00;
    pal_rgb  = 24'h000000;
    rgb_next = 24'h000000;
    case (bus.fb_data)
      2'd1:    level = 8'h55;
      2'd2:    level = 8'hAA;
      2'd3:    level = 8'hFF;
      default: level = 8'h00;
    endcase
    case (pal_q)
      2'd0:    pal_rgb = {level, level, level};
      2'd1:    pal_rgb = {level, 16'h0000};
      2'd2:    pal_rgb = {8'h00, level, 8'h00};
      default: pal_rgb = {16'h0000, level};
    endcase
    if (!de_pipe[1])
      rgb_next = 24'h000000;
    else if (!img_pipe[1] || (bus.fb_data == 2'd0))
      rgb_next = bg_q;
    else
      rgb_next = pal_rgb;
  end

  assign bus.fb_addr = addr_q;
  assign bus.rgb     = rgb_q;
  assign bus.de_out  = de_o;
  assign bus.hs_out  = hs_o;
  assign bus.vs_out  = vs_o;

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout_reader.sv
// -----------------------------------------------------------------------------
// tb_fb_scanout_reader: directed vectors for scaling, latency, borders and palettes
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fb_scanout_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_scanout_reader_if bus ();

  fb_scanout_reader #(
    .H_SCALE (10),
    .V_SCALE (11),
    .V_OFFSET(8),
    .FB_W    (128),
    .FB_H    (64)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Registered-read frame buffer: index = addr[1:0] unless a fixed value is forced.
  logic       force_en  = 1'b0;
  logic [1:0] force_val = 2'd0;
  always @(posedge clk) bus.fb_data <= force_en ? force_val : bus.fb_addr[1:0];

  typedef struct {
    logic de, hs, vs;
    logic ede, ehs, evs;
  } lat_vec_t;

  typedef struct {
    logic [1:0]  pal;
    logic [23:0] bg;
    int          line;
    logic [1:0]  fbv;
    logic [23:0] exp_rgb;
  } pal_vec_t;

  lat_vec_t lv [11];
  pal_vec_t pv [10];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
    end
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs);
    bus.de_in = de;
    bus.hs_in = hs;
    bus.vs_in = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame(input logic [1:0] pal, input logic [23:0] bg);
    bus.palette  = pal;
    bus.bgcolour = bg;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Output equals the inputs applied two drive() calls earlier (3-cycle latency).
    lv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    lv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    lv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    lv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    lv[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    lv[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    lv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    lv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    lv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    lv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    lv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    pv[0] = '{2'd2, 24'h123456,  8, 2'd3, 24'h00FF00};
    pv[1] = '{2'd2, 24'h123456,  8, 2'd0, 24'h123456};
    pv[2] = '{2'd0, 24'h0A0B0C,  8, 2'd1, 24'h555555};
    pv[3] = '{2'd0, 24'h0A0B0C,  8, 2'd2, 24'hAAAAAA};
    pv[4] = '{2'd1, 24'h654321,  8, 2'd3, 24'hFF0000};
    pv[5] = '{2'd1, 24'h654321,  9, 2'd1, 24'h550000};
    pv[6] = '{2'd3, 24'hABCDEF,  8, 2'd1, 24'h000055};
    pv[7] = '{2'd3, 24'hABCDEF,  8, 2'd2, 24'h0000AA};
    pv[8] = '{2'd0, 24'h123456,  3, 2'd3, 24'h123456};
    pv[9] = '{2'd2, 24'h778899, 10, 2'd2, 24'h00AA00};

    rst_n        = 1'b0;
    bus.de_in    = 1'b0;
    bus.hs_in    = 1'b0;
    bus.vs_in    = 1'b0;
    bus.palette  = 2'd0;
    bus.bgcolour = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    check("reset rgb",     bus.rgb,              24'h000000);
    check("reset de_out",  24'(bus.de_out),      24'h0);
    check("reset hs_out",  24'(bus.hs_out),      24'h0);
    check("reset vs_out",  24'(bus.vs_out),      24'h0);
    check("reset fb_addr", 24'(bus.fb_addr),     24'h0);
    rst_n = 1'b1;
    blank(4);

    foreach (lv[i]) begin
      drive(lv[i].de, lv[i].hs, lv[i].vs);
      check($sformatf("latency de_out[%0d]", i), 24'(bus.de_out), 24'(lv[i].ede));
      check($sformatf("latency hs_out[%0d]", i), 24'(bus.hs_out), 24'(lv[i].ehs));
      check($sformatf("latency vs_out[%0d]", i), 24'(bus.vs_out), 24'(lv[i].evs));
    end

    foreach (pv[i]) begin
      force_en  = 1'b1;
      force_val = pv[i].fbv;
      new_frame(pv[i].pal, pv[i].bg);
      short_lines(pv[i].line);
      pixels(4);
      check($sformatf("palette rgb[%0d]", i), bus.rgb, pv[i].exp_rgb);
      check($sformatf("palette de_out[%0d]", i), 24'(bus.de_out), 24'h1);
      blank(2);
    end

    // Scaling over the first image line, then rows 1 and 63 and the bottom border
    force_en = 1'b0;
    new_frame(2'd0, 24'h123456);
    short_lines(8);
    for (int x = 0; x < 1280; x++) begin
      drive(1'b1, 1'b0, 1'b0);
      case (x)
        0:       check("line8 addr x0",    24'(bus.fb_addr), 24'h0000);
        7:       check("line8 rgb px5",    bus.rgb,          24'h123456);
        9:       check("line8 addr x9",    24'(bus.fb_addr), 24'h0000);
        10:      check("line8 addr x10",   24'(bus.fb_addr), 24'h0001);
        19:      check("line8 addr x19",   24'(bus.fb_addr), 24'h0001);
        27:      check("line8 rgb px25",   bus.rgb,          24'hAAAAAA);
        37:      check("line8 rgb px35",   bus.rgb,          24'hFFFFFF);
        1279:    check("line8 addr x1279", 24'(bus.fb_addr), 24'h007F);
        default: ;
      endcase
    end
    blank(2);
    short_lines(10);
    drive(1'b1, 1'b0, 1'b0);
    check("line19 addr x0", 24'(bus.fb_addr), 24'h0080);
    pixels(3);
    blank(2);
    short_lines(691);
    for (int x = 0; x < 1280; x++) begin
      drive(1'b1, 1'b0, 1'b0);
      case (x)
        0:       check("line711 addr x0",    24'(bus.fb_addr), 24'h1F80);
        640:     check("line711 addr x640",  24'(bus.fb_addr), 24'h1FC0);
        1279:    check("line711 addr x1279", 24'(bus.fb_addr), 24'h1FFF);
        default: ;
      endcase
    end
    blank(2);
    pixels(4);
    check("line712 rgb",     bus.rgb,          24'h123456);
    check("line712 de_out",  24'(bus.de_out),  24'h1);
    check("line712 addr",    24'(bus.fb_addr), 24'h1FFF);
    blank(2);

    // Palette changed mid-frame only takes effect at the next frame start
    force_en  = 1'b1;
    force_val = 2'd3;
    new_frame(2'd2, 24'h0F0F0F);
    short_lines(8);
    pixels(4);
    check("midframe before", bus.rgb, 24'h00FF00);
    bus.palette  = 2'd1;
    bus.bgcolour = 24'hFFFFFF;
    blank(2);
    pixels(4);
    check("midframe held", bus.rgb, 24'h00FF00);
    blank(2);
    new_frame(2'd1, 24'h0F0F0F);
    short_lines(8);
    pixels(4);
    check("midframe next frame", bus.rgb, 24'hFF0000);
    blank(2);

    // Overlong active line saturates at the last column
    force_en = 1'b0;
    new_frame(2'd0, 24'h000000);
    short_lines(8);
    for (int x = 0; x < 1400; x++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (x == 1270) check("overlong addr x1270", 24'(bus.fb_addr), 24'h007F);
      if (x == 1399) check("overlong addr x1399", 24'(bus.fb_addr), 24'h007F);
    end
    blank(2);
    for (int x = 0; x < 12; x++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (x == 0)  check("after overlong x0",  24'(bus.fb_addr), 24'h0000);
      if (x == 10) check("after overlong x10", 24'(bus.fb_addr), 24'h0001);
    end
    blank(2);

    // vs_in rise together with de_in fall: counters must restart from line 0
    force_en  = 1'b1;
    force_val = 2'd3;
    new_frame(2'd0, 24'h123456);
    short_lines(3);
    pixels(2);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    short_lines(7);
    pixels(4);
    check("collide line7 border", bus.rgb, 24'h123456);
    blank(2);
    pixels(4);
    check("collide line8 image", bus.rgb, 24'hFFFFFF);
    blank(2);

    // Asynchronous reset in the middle of an active line
    new_frame(2'd0, 24'h123456);
    short_lines(19);
    pixels(4);
    check("pre-reset rgb",  bus.rgb,          24'hFFFFFF);
    check("pre-reset addr", 24'(bus.fb_addr), 24'h0080);
    rst_n = 1'b0;
    #1;
    check("midline reset rgb",    bus.rgb,          24'h000000);
    check("midline reset de_out", 24'(bus.de_out),  24'h0);
    check("midline reset addr",   24'(bus.fb_addr), 24'h0000);
    pixels(2);
    rst_n = 1'b1;
    pixels(2);
    blank(2);
    new_frame(2'd0, 24'h123456);
    short_lines(8);
    drive(1'b1, 1'b0, 1'b0);
    check("post-reset line8 addr", 24'(bus.fb_addr), 24'h0000);
    pixels(3);
    check("post-reset line8 rgb", bus.rgb, 24'hFFFFFF);
    blank(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
- Display-side reader for the 2-bit-per-pixel frame buffer (8192 x 2-bit, 13-bit address, registered read port).
- Takes raw raster timing from the HDMI timing generator and scales it to a 128x64 framebuffer image on a 1280x720 raster.
- Drives the buffer's internal read address, maps each returned 2-bit index through the selected palette, and outputs 24-bit RGB with delay-matched sync/DE to the HDMI encoder.
- The CPU-side writer port is outside this block.

Parameters:
- H_SCALE, 10: raster pixels per framebuffer pixel, horizontal.
- V_SCALE, 11: raster lines per framebuffer row.
- V_OFFSET, 8: active lines of top border before framebuffer row 0.
- FB_W, 128: framebuffer width in pixels.
- FB_H, 64: framebuffer height in rows.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- de_in  in  1  active-video enable from timing generator
- hs_in  in  1  hsync from timing generator
- vs_in  in  1  vsync from timing generator, active-high
- palette  in  2  palette select
- bgcolour  in  24  background RGB from frame buffer reserved words
- fb_addr  out  13  frame buffer read address (addr_internal)
- fb_data  in  2  frame buffer read data, valid 1 cycle after fb_addr
- rgb  out  24  pixel colour {R,G,B}
- de_out  out  1  delayed de_in
- hs_out  out  1  delayed hs_in
- vs_out  out  1  delayed vs_in

Behaviour:
- Reset (rst_n low, async): all counters 0; fb_addr 0; rgb 0; de_out, hs_out, vs_out 0; pal_q 0; bg_q 0; delay pipes cleared. Reset mid-frame resumes cleanly at the next vs_in rising edge.
- Frame start (vs_in rising edge, detected against a registered copy):
  - pal_q <= palette; bg_q <= bgcolour.
  - Line counter, v_sub and fb_y cleared.
  - Palette and background are frozen for the whole frame; mid-frame changes take effect next frame.
- Horizontal counting:
  - While de_in is low: h_sub = 0 and fb_x = 0.
  - While de_in is high: h_sub increments; at H_SCALE-1 it wraps to 0 and fb_x increments.
  - fb_x saturates at FB_W-1 and never wraps into the next row.
- Vertical counting (advanced on the de_in falling edge, i.e. end of each active line):
  - line_cnt increments, saturating at 1023.
  - Once line_cnt >= V_OFFSET, v_sub increments; at V_SCALE-1 it wraps to 0 and fb_y increments.
  - fb_y stops at FB_H; the value FB_H means "bottom border".
- Region flag in_img = (line_cnt >= V_OFFSET) && (fb_y < FB_H). With defaults: lines 0-7 are border, lines 8-711 are image, lines 712-719 are border.
- Address: fb_addr <= {fb_y[5:0], fb_x[6:0]}, registered every cycle, at cycle N+1 for raster pixel N. fb_addr is held at its last value outside in_img.
- Reserved words 0x1FF3-0x1FFF (row 63, x 115-127) are scanned as ordinary pixels; no special casing.
- Pipeline latency is exactly 3 cycles:
  - Cycle N: de_in, hs_in, vs_in and in_img sampled.
  - Cycle N+1: fb_addr registered.
  - Cycle N+2: fb_data valid.
  - Cycle N+3: rgb, de_out, hs_out and vs_out registered.
  - de, hs, vs and in_img travel through matching 3-stage shift registers.
- Colour map at stage 3, using the delayed flags:
  - de_d3 = 0: rgb = 0x000000.
  - de_d3 = 1 and in_img_d3 = 0: rgb = bg_q.
  - de_d3 = 1 and in_img_d3 = 1 and fb_data = 0: rgb = bg_q (index 0 is the background).
  - fb_data = 1, 2, 3 select from the pal_q table:
    - pal 0 grey: 0x555555, 0xAAAAAA, 0xFFFFFF
    - pal 1 red: 0x550000, 0xAA0000, 0xFF0000
    - pal 2 green: 0x005500, 0x00AA00, 0x00FF00
    - pal 3 blue: 0x000055, 0x0000AA, 0x0000FF
- Simultaneous vs_in rise and de_in fall in the same cycle: the frame reset wins and counters are cleared.
- A de_in high pulse longer than FB_W*H_SCALE cycles repeats pixel FB_W-1 (saturation); no address wrap.

Test Plan:
- Reset mid-line (rst_n low while de_in high) -> same cycle rgb = 0, de_out = 0, fb_addr = 0; after release and one vs_in pulse, line 8 pixel 0 requests fb_addr 0x0000.
- Latency: hs_in/vs_in/de_in toggled at cycle N -> hs_out/vs_out/de_out toggle at exactly N+3.
- Scaling: model fb with index = addr[1:0]; line 8 raster x 0-9 -> fb_addr 0x0000, x 10-19 -> 0x0001, x 1279 -> 0x007F; line 19 -> row 1, fb_addr 0x0080 at x 0.
- Borders: bgcolour 0x123456 latched at vsync -> lines 0-7 and 712-719 output 0x123456 with de_out = 1; line 711 still addresses row 63 (0x1F80..0x1FFF).
- Palette: palette = 2, fb_data = 3 -> rgb 0x00FF00; fb_data = 0 -> rgb = bg_q; change palette to 1 mid-frame -> colours unchanged until the next vs_in rise, then 0xFF0000.
- Overlong de_in (1400 cycles) -> fb_addr holds 0x..7F from x 1270 onward; the next line starts at x = 0.
